// File: rtl/lsu_wb_arbiter.sv
// rtl/lsu_wb_arbiter.sv - two-master round-robin Wishbone arbiter with no-ack watchdog
//
// Purpose: shares the core Wishbone master port between the LSU uncached/MMIO
// path (m0) and the fetch/PTW uncached path (m1). The grant is held for a whole
// bus cycle and released on ack, master abort (cyc dropped) or watchdog timeout.
// A timeout returns a one-cycle error pulse to the owner so a missing slave
// cannot deadlock the core.
//
// Ports:
//   clk, rstn          clock (rising edge), reset (asynchronous, active-high)
//   m0_*_i / m0_*_o    master 0 request inputs and ack/err/read-data outputs
//   m1_*_i / m1_*_o    master 1 request inputs and ack/err/read-data outputs
//   wb_*_o / wb_*_i    slave-side Wishbone bus
//   grant_o            one-hot current owner: 01 = m0, 10 = m1, 00 = none
module lsu_wb_arbiter #(
  parameter int ADDR_LEN = 39,
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_LEN-1:0]   m0_adr_i,
  input  logic [DATA_LEN-1:0]   m0_dat_i,
  input  logic [DATA_LEN/8-1:0] m0_sel_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic [DATA_LEN-1:0]   m0_dat_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_LEN-1:0]   m1_adr_i,
  input  logic [DATA_LEN-1:0]   m1_dat_i,
  input  logic [DATA_LEN/8-1:0] m1_sel_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [DATA_LEN-1:0]   m1_dat_o,

  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_LEN-1:0]   wb_adr_o,
  output logic [DATA_LEN-1:0]   wb_dat_o,
  output logic [DATA_LEN/8-1:0] wb_sel_o,
  input  logic                  wb_ack_i,
  input  logic [DATA_LEN-1:0]   wb_dat_i,

  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] TO_MAX  = '1;

  state_t              state, next_state;
  logic                last_grant, next_last_grant;
  logic [TO_WIDTH-1:0] cnt, next_cnt;

  logic req0, req1;

  // Owner-selected view of the granted master's inputs.
  logic                  own_cyc, own_stb, own_we;
  logic [ADDR_LEN-1:0]   own_adr;
  logic [DATA_LEN-1:0]   own_dat;
  logic [DATA_LEN/8-1:0] own_sel;
  logic                  timeout;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
      cnt        <= next_cnt;
    end
  end

  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    next_cnt        = cnt;

    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    timeout = 1'b0;

    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;

    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    grant_o  = 2'b00;

    case (state)
      IDLE: begin
        // On a tie the master that did not own the bus last time wins.
        if (req0 && (!req1 || last_grant)) begin
          next_state      = OWN0;
          next_last_grant = 1'b0;
          next_cnt        = '0;
        end else if (req1) begin
          next_state      = OWN1;
          next_last_grant = 1'b1;
          next_cnt        = '0;
        end
      end

      OWN0, OWN1: begin
        if (state == OWN1) begin
          own_cyc = m1_cyc_i;
          own_stb = m1_stb_i;
          own_we  = m1_we_i;
          own_adr = m1_adr_i;
          own_dat = m1_dat_i;
          own_sel = m1_sel_i;
          grant_o = 2'b10;
        end else begin
          own_cyc = m0_cyc_i;
          own_stb = m0_stb_i;
          own_we  = m0_we_i;
          own_adr = m0_adr_i;
          own_dat = m0_dat_i;
          own_sel = m0_sel_i;
          grant_o = 2'b01;
        end

        // Priority: ack, then abort, then watchdog. An aborting master gets no err.
        timeout = !wb_ack_i && own_cyc && (cnt == TO_LAST);

        wb_cyc_o = own_cyc & ~timeout;
        wb_stb_o = own_stb & ~timeout;
        wb_we_o  = own_we;
        wb_adr_o = own_adr;
        wb_dat_o = own_dat;
        wb_sel_o = own_sel;

        if (state == OWN1) begin
          m1_ack_o = wb_ack_i;
          m1_err_o = timeout;
          m1_dat_o = wb_dat_i;
        end else begin
          m0_ack_o = wb_ack_i;
          m0_err_o = timeout;
          m0_dat_o = wb_dat_i;
        end

        // Leaving always passes through IDLE, guaranteeing a dead cycle on wb_cyc_o.
        if (wb_ack_i || !own_cyc || timeout) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (cnt != TO_MAX) begin
          next_cnt = cnt + 1'b1;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_wb_arbiter.sv
// tb/tb_lsu_wb_arbiter.sv - scoreboard testbench for lsu_wb_arbiter
module tb_lsu_wb_arbiter;

  localparam int AL = 39;
  localparam int DL = 32;
  localparam logic [AL-1:0] A0 = 39'h00_1000_0000;
  localparam logic [AL-1:0] A1 = 39'h7F_0000_1000;
  localparam logic [DL-1:0] W1 = 32'h1234_5678;

  logic clk, rstn;
  logic m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AL-1:0] m0_adr_i;
  logic [DL-1:0] m0_dat_i;
  logic [3:0]    m0_sel_i;
  logic          m0_ack_o, m0_err_o;
  logic [DL-1:0] m0_dat_o;
  logic m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AL-1:0] m1_adr_i;
  logic [DL-1:0] m1_dat_i;
  logic [3:0]    m1_sel_i;
  logic          m1_ack_o, m1_err_o;
  logic [DL-1:0] m1_dat_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AL-1:0] wb_adr_o;
  logic [DL-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_ack_i;
  logic [DL-1:0] wb_dat_i;
  logic [1:0]    grant_o;

  lsu_wb_arbiter #(
    .ADDR_LEN(AL),
    .DATA_LEN(DL),
    .TIMEOUT (4),
    .TO_WIDTH(8)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .grant_o (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    g;
    logic          cyc;
    logic          we;
    logic [AL-1:0] adr;
    logic [DL-1:0] wdat;
    logic [3:0]    sel;
    logic          a0, e0;
    logic [DL-1:0] d0;
    logic          a1, e1;
    logic [DL-1:0] d1;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL cycle %0d %s: got %0h expected %0h", cyc_idx, name, act, want);
    end
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle away from the clock edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant_o",  64'(grant_o),  64'(e.g));
      chk("wb_cyc_o", 64'(wb_cyc_o), 64'(e.cyc));
      chk("wb_stb_o", 64'(wb_stb_o), 64'(e.cyc));
      chk("wb_we_o",  64'(wb_we_o),  64'(e.we));
      chk("wb_adr_o", 64'(wb_adr_o), 64'(e.adr));
      chk("wb_dat_o", 64'(wb_dat_o), 64'(e.wdat));
      chk("wb_sel_o", 64'(wb_sel_o), 64'(e.sel));
      chk("m0_ack_o", 64'(m0_ack_o), 64'(e.a0));
      chk("m0_err_o", 64'(m0_err_o), 64'(e.e0));
      chk("m0_dat_o", 64'(m0_dat_o), 64'(e.d0));
      chk("m1_ack_o", 64'(m1_ack_o), 64'(e.a1));
      chk("m1_err_o", 64'(m1_err_o), 64'(e.e1));
      chk("m1_dat_o", 64'(m1_dat_o), 64'(e.d1));
      cyc_idx++;
    end
  end

  task automatic pex(input logic [1:0] g, input logic cyc, input logic we,
                     input logic [AL-1:0] adr, input logic [DL-1:0] wdat,
                     input logic [3:0] sel, input logic a0, input logic e0,
                     input logic [DL-1:0] d0, input logic a1, input logic e1,
                     input logic [DL-1:0] d1);
    exp_t e;
    e.g = g; e.cyc = cyc; e.we = we; e.adr = adr; e.wdat = wdat; e.sel = sel;
    e.a0 = a0; e.e0 = e0; e.d0 = d0; e.a1 = a1; e.e1 = e1; e.d1 = d1;
    exp_q.push_back(e);
  endtask

  task automatic e_idle();
    pex(2'b00, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // m0 always issues reads of A0 with sel f.
  task automatic e_m0(input logic cyc, input logic a0, input logic [DL-1:0] d0);
    pex(2'b01, cyc, 1'b0, A0, '0, 4'hf, a0, 1'b0, d0, 1'b0, 1'b0, '0);
  endtask

  // m1 always issues writes of W1 to A1 with sel 3.
  task automatic e_m1(input logic cyc, input logic a1, input logic e1, input logic [DL-1:0] d1);
    pex(2'b10, cyc, 1'b1, A1, W1, 4'h3, 1'b0, 1'b0, '0, a1, e1, d1);
  endtask

  task automatic drive0(input logic c, input logic s);
    m0_cyc_i = c; m0_stb_i = s; m0_we_i = 1'b0;
    m0_adr_i = A0; m0_dat_i = '0; m0_sel_i = 4'hf;
  endtask

  task automatic drive1(input logic c, input logic s);
    m1_cyc_i = c; m1_stb_i = s; m1_we_i = 1'b1;
    m1_adr_i = A1; m1_dat_i = W1; m1_sel_i = 4'h3;
  endtask

  task automatic slave(input logic ack, input logic [DL-1:0] rd);
    wb_ack_i = ack; wb_dat_i = rd;
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1;
    drive0(1'b0, 1'b0);
    drive1(1'b0, 1'b0);
    slave(1'b0, '0);
    @(posedge clk); #1;

    // Reset state
    e_idle(); nc();
    rstn = 1'b0; e_idle(); nc();

    // m0 single read, ack on cycle 3
    drive0(1'b1, 1'b1); e_idle(); nc();
    e_m0(1'b1, 1'b0, '0); nc();
    e_m0(1'b1, 1'b0, '0); nc();
    slave(1'b1, 32'hDEAD_BEEF); e_m0(1'b1, 1'b1, 32'hDEAD_BEEF); nc();
    slave(1'b0, '0); drive0(1'b0, 1'b0); e_idle(); nc();

    // Asynchronous reset in the middle of an m0 cycle
    drive0(1'b1, 1'b1); e_idle(); nc();
    e_m0(1'b1, 1'b0, '0); nc();
    rstn = 1'b1; e_idle(); nc();

    // Tie right after reset: m0 first, then m1, then m0 again
    rstn = 1'b0; drive1(1'b1, 1'b1); e_idle(); nc();
    e_m0(1'b1, 1'b0, '0); nc();
    slave(1'b1, 32'hCAFE_F00D); e_m0(1'b1, 1'b1, 32'hCAFE_F00D); nc();
    slave(1'b0, '0); e_idle(); nc();
    e_m1(1'b1, 1'b0, 1'b0, '0); nc();
    slave(1'b1, 32'h0000_0055); e_m1(1'b1, 1'b1, 1'b0, 32'h0000_0055); nc();
    slave(1'b0, '0); drive1(1'b0, 1'b0); e_idle(); nc();
    slave(1'b1, 32'h0000_0001); e_m0(1'b1, 1'b1, 32'h0000_0001); nc();
    slave(1'b0, '0); drive0(1'b0, 1'b0); e_idle(); nc();

    // Timeout: m1 write, no ack ever
    drive1(1'b1, 1'b1); e_idle(); nc();
    e_m1(1'b1, 1'b0, 1'b0, '0); nc();
    e_m1(1'b1, 1'b0, 1'b0, '0); nc();
    e_m1(1'b1, 1'b0, 1'b0, '0); nc();
    e_m1(1'b0, 1'b0, 1'b1, '0); nc();
    drive1(1'b0, 1'b0); e_idle(); nc();

    // Ack arrives in the timeout cycle: ack wins
    drive0(1'b1, 1'b1); e_idle(); nc();
    e_m0(1'b1, 1'b0, '0); nc();
    e_m0(1'b1, 1'b0, '0); nc();
    e_m0(1'b1, 1'b0, '0); nc();
    slave(1'b1, 32'hA5A5_A5A5); e_m0(1'b1, 1'b1, 32'hA5A5_A5A5); nc();
    slave(1'b0, '0); drive0(1'b0, 1'b0); e_idle(); nc();

    // Abort by m0 while m1 waits
    drive0(1'b1, 1'b1); e_idle(); nc();
    drive1(1'b1, 1'b1); e_m0(1'b1, 1'b0, '0); nc();
    drive0(1'b0, 1'b0); e_m0(1'b0, 1'b0, '0); nc();
    e_idle(); nc();
    e_m1(1'b1, 1'b0, 1'b0, '0); nc();
    slave(1'b1, '0); e_m1(1'b1, 1'b1, 1'b0, '0); nc();
    slave(1'b0, '0); drive1(1'b0, 1'b0); e_idle(); nc();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) nc();
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
